frame_transmitter: RTL and testbench

//   Parametrised single-clock successor to the encoder+modulator transmitter.

---
 rtl/frame_transmitter.sv | 228 ++++++++++++++++++++++
 tb/tb_frame_transmitter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : frame_transmitter
// Description : Serial frame transmitter. Each frame is an uncoded sync word,
//               a rate-1/2 K=3 convolutionally coded payload (generators 7,5
//               octal) and a two-bit zero tail that flushes the encoder.
//               Every chip is held for BIT_PERIOD clocks on data_o.
//               Optional build macro: MANCHESTER_EN (Manchester line coding;
//               the default build without it drives NRZ).
// Revision    : 1.0 - initial release
// ============================================================================
module frame_transmitter #(
  parameter int                  SYNC_LEN     = 16,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD    = 16'hA5C3,
  parameter int                  PAYLOAD_BITS = 32,
  parameter int                  BIT_PERIOD   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic data_i,
  input  logic valid_i,
  output logic ready_o,
  output logic data_o,
  output logic busy_o,
  output logic frame_done_o,
  output logic underrun_o
);

  // Chip index range covers the longest segment (sync, coded payload, tail).
  localparam int PAY_CHIPS = 2 * PAYLOAD_BITS;
  localparam int SEG_MAX_A = (SYNC_LEN > PAY_CHIPS) ? SYNC_LEN : PAY_CHIPS;
  localparam int IDX_MAX   = ((SEG_MAX_A > 4) ? SEG_MAX_A : 4) - 1;
  localparam int IDX_W     = $clog2(IDX_MAX + 1);
  localparam int CHIP_W    = $clog2(BIT_PERIOD);

  localparam logic [IDX_W-1:0]  SYNC_LAST  = IDX_W'(SYNC_LEN - 1);
  localparam logic [IDX_W-1:0]  PAY_LAST   = IDX_W'(PAY_CHIPS - 1);
  localparam logic [IDX_W-1:0]  TAIL_FETCH = IDX_W'(1);
  localparam logic [IDX_W-1:0]  TAIL_LAST  = IDX_W'(3);
  localparam logic [CHIP_W-1:0] CHIP_LAST  = CHIP_W'(BIT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SYNC    = 2'd1,
    S_PAYLOAD = 2'd2,
    S_TAIL    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CHIP_W-1:0]   chip_q, chip_d;      // clock within the current chip
  logic [IDX_W-1:0]    idx_q, idx_d;        // chip index within the segment
  logic                s1_q, s1_d;          // encoder shift register
  logic                s2_q, s2_d;
  logic [1:0]          pair_q, pair_d;      // {g0, g1} of the bit being sent
  logic                underrun_q, underrun_d;

  logic                w_chip_last;
  logic                w_fetch;             // an encoder input bit is taken
  logic                w_fetch_u;           // value of that input bit
  logic                w_ready;
  logic                w_done;
  logic                w_chip;              // current chip value before line coding

  // State, counter and encoder registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      chip_q     <= '0;
      idx_q      <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      pair_q     <= 2'b00;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      chip_q     <= chip_d;
      idx_q      <= idx_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      pair_q     <= pair_d;
      underrun_q <= underrun_d;
    end
  end

  // Next-state logic: chip timing, segment sequencing and payload fetch.
  always_comb begin
    state_d     = state_q;
    chip_d      = chip_q;
    idx_d       = idx_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    pair_d      = pair_q;
    underrun_d  = underrun_q;
    w_fetch     = 1'b0;
    w_fetch_u   = 1'b0;
    w_ready     = 1'b0;
    w_done      = 1'b0;
    w_chip_last = (chip_q == CHIP_LAST);

    case (state_q)
      S_IDLE: begin
        // A start request is not a payload bit; data_i is left alone here.
        if (valid_i) begin
          state_d    = S_SYNC;
          chip_d     = '0;
          idx_d      = '0;
          s1_d       = 1'b0;
          s2_d       = 1'b0;
          underrun_d = 1'b0;
        end
      end

      S_SYNC: begin
        if (w_chip_last) begin
          chip_d = '0;
          if (idx_q == SYNC_LAST) begin
            // Fetch payload bit 0 so its g0 chip follows without a gap.
            state_d   = S_PAYLOAD;
            idx_d     = '0;
            w_ready   = 1'b1;
            w_fetch   = 1'b1;
            w_fetch_u = valid_i & data_i;
            if (!valid_i) begin
              underrun_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          chip_d = chip_q + CHIP_W'(1);
        end
      end

      S_PAYLOAD: begin
        if (w_chip_last) begin
          chip_d = '0;
          if (idx_q == PAY_LAST) begin
            // Last g1 chip done: first tail bit (a zero) enters the encoder.
            state_d   = S_TAIL;
            idx_d     = '0;
            w_fetch   = 1'b1;
            w_fetch_u = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if (idx_q[0]) begin
              // End of a g1 chip: take the next payload bit, never stall.
              w_ready   = 1'b1;
              w_fetch   = 1'b1;
              w_fetch_u = valid_i & data_i;
              if (!valid_i) begin
                underrun_d = 1'b1;
              end
            end
          end
        end else begin
          chip_d = chip_q + CHIP_W'(1);
        end
      end

      S_TAIL: begin
        if (w_chip_last) begin
          chip_d = '0;
          if (idx_q == TAIL_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
            w_done  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == TAIL_FETCH) begin
              w_fetch   = 1'b1;
              w_fetch_u = 1'b0;
            end
          end
        end else begin
          chip_d = chip_q + CHIP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Encoder step: outputs use the pre-shift state, then shift in u.
    if (w_fetch) begin
      pair_d = {w_fetch_u ^ s1_q ^ s2_q, w_fetch_u ^ s2_q};
      s1_d   = w_fetch_u;
      s2_d   = s1_q;
    end
  end

  // Chip selection: sync bit MSB first, otherwise g0 on even and g1 on odd chips.
  always_comb begin
    w_chip = 1'b0;
    case (state_q)
      S_SYNC: begin
        for (int i = 0; i < SYNC_LEN; i++) begin
          if (idx_q == IDX_W'(i)) begin
            w_chip = SYNC_WORD[SYNC_LEN-1-i];
          end
        end
      end
      S_PAYLOAD, S_TAIL: begin
        w_chip = idx_q[0] ? pair_q[0] : pair_q[1];
      end
      default: begin
        w_chip = 1'b0;
      end
    endcase
  end

  assign busy_o       = (state_q != S_IDLE);
  assign ready_o      = w_ready;
  assign frame_done_o = w_done;
  assign underrun_o   = underrun_q;

`ifdef MANCHESTER_EN
  // First half of each chip carries the chip, second half its complement.
  localparam logic [CHIP_W-1:0] CHIP_HALF = CHIP_W'(BIT_PERIOD / 2);
  assign data_o = busy_o & (w_chip ^ (chip_q >= CHIP_HALF));
`else
  // NRZ: chip held for the whole period; w_chip is already 0 in IDLE.
  assign data_o = w_chip;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_frame_transmitter
// Description : Self-checking bench for frame_transmitter. A reference
//               convolutional encoder pushes the expected line samples to a
//               queue as payload bits are handed over; the line is popped and
//               compared every clock while a frame is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_transmitter;

  localparam int          SYNC_LEN   = 16;
  localparam logic [15:0] SYNC_WORD  = 16'hA5C3;
  localparam int          PB         = 32;
  localparam int          BP         = 4;
  localparam int          FRAME_CLKS = (SYNC_LEN + 2 * (PB + 2)) * BP;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic data_i = 1'b0;
  logic valid_i = 1'b0;
  logic ready_o, data_o, busy_o, frame_done_o, underrun_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_q[$];
  logic ms1, ms2;

  always #5 clk = ~clk;

  frame_transmitter #(
    .SYNC_LEN    (SYNC_LEN),
    .SYNC_WORD   (SYNC_WORD),
    .PAYLOAD_BITS(PB),
    .BIT_PERIOD  (BP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_o      (data_o),
    .busy_o      (busy_o),
    .frame_done_o(frame_done_o),
    .underrun_o  (underrun_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected line samples for one chip.
  task automatic push_chip(input logic c);
    for (int k = 0; k < BP; k++) begin
`ifdef MANCHESTER_EN
      exp_q.push_back((k < BP / 2) ? c : ~c);
`else
      exp_q.push_back(c);
`endif
    end
  endtask

  // Reference rate-1/2 encoder, generators 7 and 5 octal.
  task automatic push_bit(input logic u);
    logic g0, g1;
    g0 = u ^ ms1 ^ ms2;
    g1 = u ^ ms2;
    push_chip(g0);
    push_chip(g1);
    ms2 = ms1;
    ms1 = u;
  endtask

  task automatic idle_cycles(input int n, input logic exp_underrun);
    for (int i = 0; i < n; i++) begin
      valid_i = 1'b0;
      data_i  = 1'($urandom);
      @(negedge clk);
      check_eq("idle_data", data_o, 0);
      check_eq("idle_busy", busy_o, 0);
      check_eq("idle_ready", ready_o, 0);
      check_eq("idle_done", frame_done_o, 0);
      check_eq("idle_underrun", underrun_o, exp_underrun);
    end
  endtask

  task automatic abort_with_reset();
    reset = 1'b1;
    #1;
    check_eq("abort_data", data_o, 0);
    check_eq("abort_busy", busy_o, 0);
    check_eq("abort_ready", ready_o, 0);
    check_eq("abort_done", frame_done_o, 0);
    check_eq("abort_underrun", underrun_o, 0);
    valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("abort_hold_done", frame_done_o, 0);
      check_eq("abort_hold_busy", busy_o, 0);
    end
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Starts a frame from an IDLE negedge and scores it. drop: index of the
  // payload bit presented with valid_i=0 (-1 for none). abort_at: frame clock
  // at which reset is applied (0 for a full frame).
  task automatic run_frame(input logic [PB-1:0] pl, input int drop, input int abort_at);
    int   cyc;
    int   bit_idx;
    int   n_ready;
    bit   done_seen;
    logic u;
    logic e;
    cyc       = 0;
    bit_idx   = 0;
    n_ready   = 0;
    done_seen = 1'b0;

    check_eq("start_busy", busy_o, 0);
    exp_q.delete();
    valid_i = 1'b1;
    data_i  = 1'($urandom);
    ms1     = 1'b0;
    ms2     = 1'b0;
    for (int i = SYNC_LEN - 1; i >= 0; i--) push_chip(SYNC_WORD[i]);
    @(negedge clk);
    check_eq("start_underrun_clr", underrun_o, 0);

    while (!done_seen && cyc < FRAME_CLKS + 8) begin
      cyc++;
      if (cyc == abort_at) begin
        abort_with_reset();
        return;
      end
      check_eq("busy", busy_o, 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      check_eq("data_o", data_o, e);

      // valid_i/data_i are don't-care except in ready cycles.
      valid_i = 1'($urandom);
      data_i  = 1'($urandom);
      if (ready_o) begin
        n_ready++;
        if (bit_idx < PB) begin
          if (bit_idx == drop) begin
            valid_i = 1'b0;
            u       = 1'b0;
          end else begin
            valid_i = 1'b1;
            data_i  = pl[bit_idx];
            u       = pl[bit_idx];
          end
          push_bit(u);
          bit_idx++;
          if (bit_idx == PB) begin
            push_bit(1'b0);
            push_bit(1'b0);
          end
        end
      end
      if (frame_done_o) begin
        done_seen = 1'b1;
        check_eq("done_cycle", cyc, FRAME_CLKS);
      end
      @(negedge clk);
    end

    check_eq("done_seen", 32'(done_seen), 1);
    check_eq("ready_count", n_ready, PB);
    check_eq("exp_drained", exp_q.size(), 0);
    check_eq("end_busy", busy_o, 0);
    check_eq("end_data", data_o, 0);
    check_eq("end_done_low", frame_done_o, 0);
    check_eq("end_underrun", underrun_o, (drop >= 0 && drop < PB) ? 1 : 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    valid_i = 1'b0;
    data_i  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_data", data_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_ready", ready_o, 0);
    check_eq("rst_done", frame_done_o, 0);
    check_eq("rst_underrun", underrun_o, 0);
    reset = 1'b0;

    // Quiet line with no start request.
    idle_cycles(50, 1'b0);

    // Single 1 followed by zeros.
    run_frame(32'h0000_0001, -1, 0);
    idle_cycles(3, 1'b0);

    // All ones.
    run_frame('1, -1, 0);
    idle_cycles(2, 1'b0);

    // Missing valid_i on bit 5: sticky underrun until the next start.
    run_frame($urandom, 5, 0);
    idle_cycles(5, 1'b1);

    // Continuous frames with the minimum single IDLE cycle between them.
    run_frame($urandom, -1, 0);
    for (int f = 0; f < 3; f++) begin
      run_frame($urandom, -1, 0);
    end

    // Abort in chip 40, then a clean frame.
    run_frame($urandom, -1, 40 * BP + 2);
    idle_cycles(2, 1'b0);
    run_frame(32'h0000_0001, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
